// File: rtl/muntjac_tl_sram_pkg.sv
// rtl/muntjac_tl_sram_pkg.sv - TileLink opcodes, SRAM device FSM states and beat helpers
package muntjac_tl_sram_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } tl_d_op_e;

  typedef logic [1:0] tl_sram_state_e;
  localparam tl_sram_state_e IDLE  = 2'd0;
  localparam tl_sram_state_e READ  = 2'd1;
  localparam tl_sram_state_e WRITE = 2'd2;
  localparam tl_sram_state_e ACK   = 2'd3;

  // Index of the final beat of a transfer: max(1, 2^size / bytes-per-beat) - 1.
  function automatic logic [6:0] last_beat(input logic [2:0] size, input int unsigned off_w);
    int unsigned sz;
    int unsigned n;
    sz = 32'(size);
    n  = (sz > off_w) ? (32'd1 << (sz - off_w)) : 32'd1;
    return 7'(n - 32'd1);
  endfunction

  // Response opcode for single-beat answers (writes, hints, rejected requests).
  function automatic logic [2:0] ack_op(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      ArithmeticData, LogicalData: r = AccessAckData;
      Intent:                      r = HintAck;
      default:                     r = AccessAck;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muntjac_tl_sram_array.sv
// rtl/muntjac_tl_sram_array.sv - single-port sync SRAM, byte write enables, optional parity (MUNTJAC_TL_SRAM_PARITY_EN)
module muntjac_tl_sram_array #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MemDepth  = 8192,
  parameter int unsigned IdxWidth  = $clog2(MemDepth)
) (
  input  logic                   clk_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [IdxWidth-1:0]    addr_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rerr_o
);
  localparam int unsigned BB = DataWidth / 8;

  logic [DataWidth-1:0] mem [MemDepth];

  // Byte-masked write or registered read; rdata holds until the next read.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < BB; b++) begin
          if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

`ifdef MUNTJAC_TL_SRAM_PARITY_EN
  logic [BB-1:0] par [MemDepth];
  logic          rerr_q;

  function automatic logic [BB-1:0] byte_parity(input logic [DataWidth-1:0] d);
    logic [BB-1:0] p;
    for (int b = 0; b < BB; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  // Parity bits travel with their bytes; a read flags any stored/recomputed mismatch.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < BB; b++) begin
          if (be_i[b]) par[addr_i][b] <= ^wdata_i[b*8 +: 8];
        end
      end else begin
        rerr_q <= |(par[addr_i] ^ byte_parity(mem[addr_i]));
      end
    end
  end

  assign rerr_o = rerr_q;
`else
  assign rerr_o = 1'b0;
`endif

endmodule

// File: rtl/muntjac_tl_sram.sv
// rtl/muntjac_tl_sram.sv - TileLink-UH A/D device backed by one SRAM; parity via MUNTJAC_TL_SRAM_PARITY_EN
module muntjac_tl_sram
  import muntjac_tl_sram_pkg::*;
#(
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SinkWidth   = 1,
  parameter int unsigned MemDepth    = 8192,
  parameter int unsigned MaxSize     = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [2:0]             a_opcode_i,
  input  logic [2:0]             a_size_i,
  input  logic [SourceWidth-1:0] a_source_i,
  input  logic [AddrWidth-1:0]   a_address_i,
  input  logic [DataWidth/8-1:0] a_mask_i,
  input  logic [DataWidth-1:0]   a_data_i,
  output logic                   d_valid_o,
  input  logic                   d_ready_i,
  output logic [2:0]             d_opcode_o,
  output logic [2:0]             d_size_o,
  output logic [SourceWidth-1:0] d_source_o,
  output logic [SinkWidth-1:0]   d_sink_o,
  output logic                   d_denied_o,
  output logic                   d_corrupt_o,
  output logic [DataWidth-1:0]   d_data_o
);
  localparam int unsigned BB   = DataWidth / 8;
  localparam int unsigned OffW = $clog2(BB);
  localparam int unsigned IdxW = $clog2(MemDepth);

  tl_sram_state_e         state_q;
  logic [6:0]             beat_q;
  logic [6:0]             last_q;
  logic [IdxW-1:0]        base_q;
  logic [2:0]             op_q;
  logic [2:0]             size_q;
  logic [SourceWidth-1:0] source_q;
  logic                   denied_q;
  logic                   d_valid_q;
  logic [2:0]             d_opcode_q;

  logic                   is_get, is_put, is_intent, has_data;
  logic                   addr_oor, misaligned, size_bad, new_denied;
  logic [IdxW-1:0]        a_idx;
  logic [6:0]             a_last;
  logic                   d_hs;

  logic                   mem_req, mem_we;
  logic [IdxW-1:0]        mem_addr;
  logic [BB-1:0]          mem_be;
  logic [DataWidth-1:0]   mem_rdata;
  logic                   mem_rerr;

  assign is_get     = (a_opcode_i == Get);
  assign is_put     = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData);
  assign is_intent  = (a_opcode_i == Intent);
  assign has_data   = !a_opcode_i[2];
  assign addr_oor   = a_address_i >= AddrWidth'(MemDepth * BB);
  assign misaligned = |(a_address_i & ~({AddrWidth{1'b1}} << a_size_i));
  assign size_bad   = a_size_i > 3'(MaxSize);
  // Intent is always acknowledged; other non-access opcodes are rejected outright.
  assign new_denied = (is_get || is_put) ? (addr_oor || misaligned || size_bad) : !is_intent;
  assign a_idx      = a_address_i[OffW +: IdxW];
  assign a_last     = last_beat(a_size_i, OffW);
  assign d_hs       = d_valid_q && d_ready_i;

  // Steer the single SRAM port: first beat straight from A in IDLE, later beats from the latched base.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = base_q | IdxW'(beat_q);
    mem_be   = '1;
    case (state_q)
      IDLE: begin
        mem_addr = a_idx;
        mem_be   = (a_opcode_i == PutFullData) ? '1 : a_mask_i;
        if (a_valid_i && !new_denied && (is_get || is_put)) begin
          mem_req = 1'b1;
          mem_we  = is_put;
        end
      end
      WRITE: begin
        mem_be = (op_q == PutFullData) ? '1 : a_mask_i;
        if (a_valid_i && !denied_q && (op_q == PutFullData || op_q == PutPartialData)) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
      end
      READ: begin
        mem_addr = base_q | IdxW'(beat_q + 7'd1);
        if (d_hs && (beat_q != last_q) && !denied_q) mem_req = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction FSM and D-channel response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_q     <= '0;
      base_q     <= '0;
      op_q       <= '0;
      size_q     <= '0;
      source_q   <= '0;
      denied_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_valid_i) begin
            op_q     <= a_opcode_i;
            size_q   <= a_size_i;
            source_q <= a_source_i;
            denied_q <= new_denied;
            base_q   <= a_idx;
            last_q   <= a_last;
            beat_q   <= '0;
            if (is_get) begin
              state_q    <= READ;
              d_valid_q  <= 1'b1;
              d_opcode_q <= AccessAckData;
            end else if (has_data && a_last != '0) begin
              state_q <= WRITE;
              beat_q  <= 7'd1;
            end else begin
              state_q    <= ACK;
              d_valid_q  <= 1'b1;
              d_opcode_q <= ack_op(a_opcode_i);
            end
          end
        end
        WRITE: begin
          if (a_valid_i) begin
            if (beat_q == last_q) begin
              state_q    <= ACK;
              d_valid_q  <= 1'b1;
              d_opcode_q <= ack_op(op_q);
            end else begin
              beat_q <= beat_q + 7'd1;
            end
          end
        end
        READ: begin
          if (d_hs) begin
            if (beat_q == last_q) begin
              state_q   <= IDLE;
              d_valid_q <= 1'b0;
            end else begin
              beat_q <= beat_q + 7'd1;
            end
          end
        end
        default: begin
          if (d_hs) begin
            state_q   <= IDLE;
            d_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  muntjac_tl_sram_array #(
    .DataWidth (DataWidth),
    .MemDepth  (MemDepth),
    .IdxWidth  (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .req_i   (mem_req),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .be_i    (mem_be),
    .wdata_i (a_data_i),
    .rdata_o (mem_rdata),
    .rerr_o  (mem_rerr)
  );

  assign a_ready_o   = (state_q == IDLE) || (state_q == WRITE);
  assign d_valid_o   = d_valid_q;
  assign d_opcode_o  = d_opcode_q;
  assign d_size_o    = size_q;
  assign d_source_o  = source_q;
  assign d_sink_o    = '0;
  assign d_denied_o  = denied_q;
  // Read data only leaves the device for a live, accepted Get; denied data beats carry zeros.
  assign d_data_o    = (d_valid_q && state_q == READ && !denied_q) ? mem_rdata : '0;
  assign d_corrupt_o = d_valid_q && ((denied_q && d_opcode_q == AccessAckData) ||
                                     (state_q == READ && !denied_q && mem_rerr));

endmodule

// File: tb/tb_muntjac_tl_sram.sv
// tb/tb_muntjac_tl_sram.sv - scoreboard bench for muntjac_tl_sram
module tb_muntjac_tl_sram;
  import muntjac_tl_sram_pkg::*;

`ifdef MUNTJAC_TL_SRAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [55:0] a_address = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [0:0]  d_sink;
  logic        d_denied;
  logic        d_corrupt;
  logic [63:0] d_data;

  always #5 clk = ~clk;

  muntjac_tl_sram dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_size_i(a_size),
    .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_size_o(d_size),
    .d_source_o(d_source), .d_sink_o(d_sink), .d_denied_o(d_denied), .d_corrupt_o(d_corrupt),
    .d_data_o(d_data)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_count = 0;
  logic [63:0] wbuf [16];
  logic        toggle_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                      input logic den, input logic cor, input logic [63:0] data);
    rsp_t e;
    e.op = op; e.size = size; e.src = src; e.denied = den; e.corrupt = cor; e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: each D handshake pops one expected beat; stalled beats must hold their data.
  initial begin
    rsp_t e;
    rsp_t act;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && d_valid) check("d_data_stable", d_data, prev_data);
        if (d_valid && d_ready) begin
          act.op = d_opcode; act.size = d_size; act.src = d_source;
          act.denied = d_denied; act.corrupt = d_corrupt; act.data = d_data;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_d_beat: got op=%0d data=%h expected no beat", d_opcode, d_data);
          end else begin
            e = exp_q.pop_front();
            if (act !== e || d_sink !== 1'b0) begin
              n_fail++;
              $display("FAIL d_beat: got op=%0d size=%0d src=%0d den=%b cor=%b sink=%b data=%h expected op=%0d size=%0d src=%0d den=%b cor=%b sink=0 data=%h",
                       act.op, act.size, act.src, act.denied, act.corrupt, d_sink, act.data,
                       e.op, e.size, e.src, e.denied, e.corrupt, e.data);
            end
          end
          hs_count++;
        end
        prev_stall = d_valid && !d_ready;
        prev_data  = d_data;
      end
    end
  end

  // D-ready driver: steady 1, or the repeating 1,0,0,1 backpressure pattern.
  initial begin
    int pi = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        d_ready = pat[3 - (pi % 4)];
        pi++;
      end else begin
        d_ready = 1'b1;
        pi = 0;
      end
    end
  end

  task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic [55:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int t = 0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    @(negedge clk);
    while (!a_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      n_checks++; n_fail++;
      $display("FAIL a_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic put(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                     input logic [55:0] addr, input logic [7:0] mask);
    int n;
    n = (size > 3) ? (1 << (size - 3)) : 1;
    for (int i = 0; i < n; i++) a_beat(op, size, src, addr, mask, wbuf[i]);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_ready", 64'(a_ready), 64'd1);
    check("reset_d_valid", 64'(d_valid), 64'd0);
    check("reset_d_fields", {37'd0, d_opcode, d_size, d_source, d_denied, d_corrupt, 16'd0}, 64'd0);
    check("reset_d_data", d_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // PutFull ignores mask, then single-beat Get with latency check.
    wbuf[0] = 64'hDEADBEEF_01234567;
    push(AccessAck, 3, 2, 0, 0, 0);
    put(PutFullData, 3, 2, 56'h40, 8'h0F);
    drain();
    push(AccessAckData, 3, 5, 0, 0, 64'hDEADBEEF_01234567);
    a_beat(Get, 3, 5, 56'h40, 8'hFF, 0);
    check("get_latency_d_valid", 64'(d_valid), 64'd1);
    drain();

    // 8-beat burst written then read under 1,0,0,1 backpressure.
    for (int i = 0; i < 8; i++) wbuf[i] = {32'hCAFE0000 + 32'(i), 32'h00001000 + 32'(i)};
    push(AccessAck, 6, 1, 0, 0, 0);
    put(PutFullData, 6, 1, 56'h200, 8'hFF);
    drain();
    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) push(AccessAckData, 6, 3, 0, 0, {32'hCAFE0000 + 32'(i), 32'h00001000 + 32'(i)});
    a_beat(Get, 6, 3, 56'h200, 8'hFF, 0);
    drain();
    toggle_en = 1'b0;

    // PutPartial low half over zeros.
    wbuf[0] = 64'd0;
    push(AccessAck, 3, 0, 0, 0, 0);
    put(PutFullData, 3, 0, 56'h80, 8'hFF);
    wbuf[0] = '1;
    push(AccessAck, 3, 0, 0, 0, 0);
    put(PutPartialData, 3, 0, 56'h80, 8'h0F);
    push(AccessAckData, 3, 0, 0, 0, 64'h00000000_FFFFFFFF);
    a_beat(Get, 3, 0, 56'h80, 8'hFF, 0);
    drain();

    // Out-of-range Get and Put (the out-of-range index aliases word 0 if it ever reached the array).
    push(AccessAckData, 3, 7, 1, 1, 0);
    a_beat(Get, 3, 7, 56'h10000, 8'hFF, 0);
    drain();
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h5555_0000_0000_0000 + 64'(i);
    push(AccessAck, 6, 4, 0, 0, 0);
    put(PutFullData, 6, 4, 56'h0, 8'hFF);
    drain();
    for (int i = 0; i < 8; i++) wbuf[i] = '1;
    push(AccessAck, 6, 4, 1, 0, 0);
    put(PutFullData, 6, 4, 56'h10000, 8'hFF);
    check("oor_put_a_ready_after_last", 64'(a_ready), 64'd0);
    check("oor_put_d_valid_after_last", 64'(d_valid), 64'd1);
    drain();
    for (int i = 0; i < 8; i++) push(AccessAckData, 6, 4, 0, 0, 64'h5555_0000_0000_0000 + 64'(i));
    a_beat(Get, 6, 4, 56'h0, 8'hFF, 0);
    drain();

    // Misaligned Get and oversize Get keep full beat accounting.
    for (int i = 0; i < 2; i++) push(AccessAckData, 4, 1, 1, 1, 0);
    a_beat(Get, 4, 1, 56'h48, 8'hFF, 0);
    drain();
    for (int i = 0; i < 16; i++) push(AccessAckData, 7, 1, 1, 1, 0);
    a_beat(Get, 7, 1, 56'h0, 8'hFF, 0);
    drain();

    // Intent and Arithmetic.
    push(HintAck, 3, 6, 0, 0, 0);
    a_beat(Intent, 3, 6, 56'h40, 8'hFF, 0);
    drain();
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    push(AccessAckData, 4, 2, 1, 1, 0);
    put(ArithmeticData, 4, 2, 56'h100, 8'hFF);
    drain();

    // Reset asserted while beat 4 of an 8-beat Get is presented.
    for (int i = 0; i < 8; i++) push(AccessAckData, 6, 9, 0, 0, {32'hCAFE0000 + 32'(i), 32'h00001000 + 32'(i)});
    target = hs_count + 4;
    a_beat(Get, 6, 9, 56'h200, 8'hFF, 0);
    t = 0;
    while (hs_count < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("reset_mid_handshakes", 64'(hs_count), 64'(target));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_d_valid", 64'(d_valid), 64'd0);
    check("reset_mid_remaining", 64'(exp_q.size()), 64'd4);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(AccessAckData, 3, 5, 0, 0, 64'hDEADBEEF_01234567);
    a_beat(Get, 3, 5, 56'h40, 8'hFF, 0);
    drain();

    // Flip one stored bit behind the device's back.
    wbuf[0] = 64'h01234567_89ABCDEF;
    push(AccessAck, 3, 3, 0, 0, 0);
    put(PutFullData, 3, 3, 56'h300, 8'hFF);
    drain();
    dut.u_array.mem[96] = 64'h01234567_89ABCDEE;
    push(AccessAckData, 3, 3, 0, PAR, 64'h01234567_89ABCDEE);
    a_beat(Get, 3, 3, 56'h300, 8'hFF, 0);
    drain();
    push(AccessAckData, 3, 3, 0, 0, 64'hDEADBEEF_01234567);
    a_beat(Get, 3, 3, 56'h40, 8'hFF, 0);
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
